// File: rtl/mem_bus_nport.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_nport
//  Purpose  : Shared main-memory bus serving NUM_PORTS caches. Round-robin
//             arbitration, fixed access latency, a single outstanding
//             transaction at a time. Backed by a word-addressed array.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             rwFromCache         - per-port op [2i+1:2i]: 00 idle, 01 read,
//                                   10 write, 11 illegal (treated as idle)
//             addrFromCache       - per-port word address (ADDR_W each)
//             dataFromCache       - per-port write data (DATA_W each)
//             dataToCache         - shared read data, valid with rdEnToCache
//             rdEnToCache         - one-hot 1-cycle read-complete pulse
//             wbDoneToCache       - one-hot 1-cycle write-committed pulse
//             debugBusy           - high while a transaction is in flight
//             debugGrant          - port currently or last granted
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_nport #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int LATENCY   = 4,
    parameter int GID_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*NUM_PORTS-1:0]      rwFromCache,
    input  logic [ADDR_W*NUM_PORTS-1:0] addrFromCache,
    input  logic [DATA_W*NUM_PORTS-1:0] dataFromCache,
    output logic [DATA_W-1:0]           dataToCache,
    output logic [NUM_PORTS-1:0]        rdEnToCache,
    output logic [NUM_PORTS-1:0]        wbDoneToCache,
    output logic                        debugBusy,
    output logic [GID_W-1:0]            debugGrant
);

    // LATENCY-1 must fit in the counter; keep at least one bit for LATENCY=1.
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [GID_W-1:0]   c_LAST_ID  = GID_W'(NUM_PORTS - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [GID_W-1:0]     r_rr;
    logic [NUM_PORTS-1:0] r_served;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [GID_W-1:0]     r_gnt;
    logic                 r_is_wr;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic                 r_busy;
    logic [NUM_PORTS-1:0] r_rd;
    logic [NUM_PORTS-1:0] r_wb;
    logic [DATA_W-1:0]    r_dout;
    logic [DATA_W-1:0]    r_mem [2**ADDR_W];

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_found;
    logic [GID_W-1:0]     w_pick;
    logic                 w_complete;

    // Only 01 and 10 count as requests; 11 is never granted.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign w_req[gi] = (rwFromCache[2*gi +: 2] == 2'b01) ||
                               (rwFromCache[2*gi +: 2] == 2'b10);
        end
    endgenerate

    // The served mask keeps the port that just finished from winning again
    // while its requester is still dropping its request line.
    assign w_elig = w_req & ~r_served;

    // Rotating-priority scan starting at the round-robin pointer.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = (int'(r_rr) + k) % NUM_PORTS;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GID_W'(w_idx);
            end
        end
    end

    assign w_complete = (r_state == c_S_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_rr     <= '0;
            r_served <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_is_wr  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_rd     <= '0;
            r_wb     <= '0;
            r_dout   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_served <= '0;
                    if (w_found) begin
                        r_gnt   <= w_pick;
                        r_is_wr <= rwFromCache[2*w_pick+1];
                        r_addr  <= addrFromCache[ADDR_W*w_pick +: ADDR_W];
                        r_data  <= dataFromCache[DATA_W*w_pick +: DATA_W];
                        r_cnt   <= c_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_busy <= 1'b0;
                        if (r_is_wr) begin
                            r_wb[r_gnt] <= 1'b1;
                        end else begin
                            r_rd[r_gnt] <= 1'b1;
                            r_dout      <= r_mem[r_addr];
                        end
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_rd            <= '0;
                    r_wb            <= '0;
                    r_rr            <= (r_gnt == c_LAST_ID) ? '0 : r_gnt + 1'b1;
                    r_served        <= '0;
                    r_served[r_gnt] <= 1'b1;
                    r_state         <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Array is not reset; a reset edge suppresses a pending commit so an
    // abandoned write never lands.
    always_ff @(posedge clk) begin
        if (!reset && w_complete && r_is_wr) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign dataToCache   = r_dout;
    assign rdEnToCache   = r_rd;
    assign wbDoneToCache = r_wb;
    assign debugBusy     = r_busy;
    assign debugGrant    = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_nport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_nport
//  Purpose  : Self-checking bench for mem_bus_nport. A transaction-level
//             scheduler model predicts grant/complete edges, pulses, read
//             data and busy/grant status every cycle; directed scenarios add
//             their own expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_nport;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2*N-1:0]  rw = '0;
    logic [AW*N-1:0] addr_bus = '0;
    logic [DW*N-1:0] data_bus = '0;
    logic [DW-1:0]   dataToCache;
    logic [N-1:0]    rdEnToCache;
    logic [N-1:0]    wbDoneToCache;
    logic            debugBusy;
    logic [GW-1:0]   debugGrant;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // requester behaviour
    bit hold [N];
    bit pend_drop [N];
    int drop_at [N];

    // reference model state
    logic [DW-1:0] m_mem [256];
    bit            m_valid [256];
    bit            m_active = 0;
    bit            m_wr = 0;
    int            m_g = 0, m_comp = 0, m_rr = 0, m_last = -1, m_free_at = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [N-1:0]  exp_rd = '0, exp_wb = '0;
    logic          exp_busy = 0;
    logic [GW-1:0] exp_grant = '0;
    logic [DW-1:0] exp_data = '0;
    bit            exp_known = 1;

    mem_bus_nport #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .GID_W(GW)) dut (
        .clk(clk), .reset(reset), .rwFromCache(rw), .addrFromCache(addr_bus),
        .dataFromCache(data_bus), .dataToCache(dataToCache), .rdEnToCache(rdEnToCache),
        .wbDoneToCache(wbDoneToCache), .debugBusy(debugBusy), .debugGrant(debugGrant));

    always #5 clk = ~clk;

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic issue(input int p, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rw[2*p +: 2]        = op;
        addr_bus[AW*p +: AW] = a;
        data_bus[DW*p +: DW] = d;
    endtask

    // One clock: advance the model at the rising edge, compare at the falling
    // edge, then let requesters withdraw after their done pulse.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (reset) begin
            m_active = 0; m_rr = 0; m_last = -1; m_free_at = edge_n + 1;
            exp_rd = '0; exp_wb = '0; exp_busy = 0; exp_grant = '0;
            exp_data = '0; exp_known = 1;
        end else begin
            exp_rd = '0; exp_wb = '0;
            if (m_active && edge_n == m_comp) begin
                if (m_wr) begin
                    m_mem[m_addr] = m_data; m_valid[m_addr] = 1; exp_wb[m_g] = 1'b1;
                end else begin
                    exp_rd[m_g] = 1'b1; exp_data = m_mem[m_addr]; exp_known = m_valid[m_addr];
                end
                m_active = 0;
                m_free_at = edge_n + 2;
            end else if (!m_active && edge_n >= m_free_at) begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    logic [1:0] op;
                    p  = (m_rr + k) % N;
                    op = rw[2*p +: 2];
                    if (!m_active && (op == 2'b01 || op == 2'b10) &&
                        !(edge_n == m_free_at && p == m_last)) begin
                        m_active = 1; m_g = p; m_comp = edge_n + L; m_wr = (op == 2'b10);
                        m_addr = addr_bus[AW*p +: AW]; m_data = data_bus[DW*p +: DW];
                        m_rr = (p + 1) % N; m_last = p; exp_grant = GW'(p);
                    end
                end
            end
            exp_busy = m_active && (edge_n < m_comp);
        end
        @(negedge clk);
        checks++;
        if (rdEnToCache !== exp_rd) begin
            failures++; $display("FAIL rdEn edge=%0d got=%b exp=%b", edge_n, rdEnToCache, exp_rd);
        end
        checks++;
        if (wbDoneToCache !== exp_wb) begin
            failures++; $display("FAIL wbDone edge=%0d got=%b exp=%b", edge_n, wbDoneToCache, exp_wb);
        end
        checks++;
        if (debugBusy !== exp_busy) begin
            failures++; $display("FAIL busy edge=%0d got=%b exp=%b", edge_n, debugBusy, exp_busy);
        end
        checks++;
        if (debugGrant !== exp_grant) begin
            failures++; $display("FAIL grant edge=%0d got=%0d exp=%0d", edge_n, debugGrant, exp_grant);
        end
        if (exp_known) begin
            checks++;
            if (dataToCache !== exp_data) begin
                failures++; $display("FAIL data edge=%0d got=%h exp=%h", edge_n, dataToCache, exp_data);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rdEnToCache[i] || wbDoneToCache[i]) begin
                if (hold[i]) begin
                    pend_drop[i] = 1; drop_at[i] = edge_n + 2;
                end else begin
                    rw[2*i +: 2] = 2'b00;
                end
            end
            if (pend_drop[i] && edge_n >= drop_at[i]) begin
                rw[2*i +: 2] = 2'b00; pend_drop[i] = 0; hold[i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rw = '0;
        for (int i = 0; i < N; i++) begin hold[i] = 0; pend_drop[i] = 0; end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (rdEnToCache !== '0 || wbDoneToCache !== '0) begin
            failures++; $display("FAIL reset_pulses got=%b/%b exp=0/0", rdEnToCache, wbDoneToCache);
        end
        checks++;
        if (dataToCache !== '0 || debugBusy !== 1'b0 || debugGrant !== '0) begin
            failures++; $display("FAIL reset_status got=%h/%b/%0d exp=0/0/0", dataToCache, debugBusy, debugGrant);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int n, e0;
        do_reset();
        issue(0, 2'b10, 8'h00, 16'h0003);
        e0 = edge_n + 1;
        n = 0;
        while (!wbDoneToCache[0] && n < 20) begin tick(); n++; end
        checks++;
        if (!wbDoneToCache[0]) begin
            failures++; $display("FAIL wr_timeout got=none exp=wbDone[0]");
        end else if (edge_n - e0 != L) begin
            failures++; $display("FAIL wr_latency got=%0d exp=%0d", edge_n - e0, L);
        end
        tick();
        checks++;
        if (wbDoneToCache !== '0) begin
            failures++; $display("FAIL wr_width got=%b exp=0", wbDoneToCache);
        end
        issue(0, 2'b01, 8'h00, 16'h0);
        n = 0;
        while (!rdEnToCache[0] && n < 20) begin tick(); n++; end
        checks++;
        if (!rdEnToCache[0] || dataToCache !== 16'h0003) begin
            failures++; $display("FAIL rd_data got=%b/%h exp=1/0003", rdEnToCache[0], dataToCache);
        end
    endtask

    task automatic test_all_ports();
        int ports [4];
        int edges [4];
        int got, n, p, e0;
        do_reset();
        for (int i = 0; i < N; i++) issue(i, 2'b10, AW'(8'h20 + i), DW'(16'h0100 + i));
        e0 = edge_n + 1;
        got = 0; n = 0;
        while (got < 4 && n < 60) begin
            tick(); n++;
            p = first_set(wbDoneToCache);
            if (p >= 0) begin ports[got] = p; edges[got] = edge_n; got++; end
        end
        checks++;
        if (got != 4) begin
            failures++; $display("FAIL all_timeout got=%0d exp=4", got);
        end else begin
            checks++;
            if (edges[0] - e0 != L) begin
                failures++; $display("FAIL all_first got=%0d exp=%0d", edges[0] - e0, L);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ports[k] != k) begin
                    failures++; $display("FAIL all_order idx=%0d got=%0d exp=%0d", k, ports[k], k);
                end
                if (k > 0) begin
                    checks++;
                    if (edges[k] - edges[k-1] != L + 2) begin
                        failures++; $display("FAIL all_spacing idx=%0d got=%0d exp=%0d", k, edges[k] - edges[k-1], L + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_last_writer();
        int got, n, first;
        do_reset();
        issue(0, 2'b10, 8'h00, 16'h0003);
        issue(1, 2'b10, 8'h00, 16'h0004);
        got = 0; n = 0; first = -1;
        while (got < 2 && n < 40) begin
            tick(); n++;
            if (wbDoneToCache != '0) begin
                if (got == 0) first = first_set(wbDoneToCache);
                got++;
            end
        end
        checks++;
        if (got != 2 || first != 0) begin
            failures++; $display("FAIL lw_writes got=%0d/%0d exp=2/0", got, first);
        end
        issue(2, 2'b01, 8'h00, 16'h0);
        n = 0;
        while (!rdEnToCache[2] && n < 20) begin tick(); n++; end
        checks++;
        if (!rdEnToCache[2] || dataToCache !== 16'h0004) begin
            failures++; $display("FAIL lw_read got=%b/%h exp=1/0004", rdEnToCache[2], dataToCache);
        end
    endtask

    task automatic test_hold();
        int n, p, pe, next_p, next_e, dup;
        do_reset();
        hold[3] = 1;
        issue(3, 2'b01, 8'h00, 16'h0);
        tick();
        issue(0, 2'b01, 8'h21, 16'h0);
        n = 0;
        while (!rdEnToCache[3] && n < 20) begin tick(); n++; end
        pe = edge_n;
        next_p = -1; next_e = 0; dup = 0; n = 0;
        while (n < 20) begin
            tick(); n++;
            p = first_set(rdEnToCache | wbDoneToCache);
            if (p == 3) dup++;
            if (p >= 0 && next_p < 0) begin next_p = p; next_e = edge_n; end
        end
        checks++;
        if (next_p != 0 || next_e - pe != L + 2) begin
            failures++; $display("FAIL hold_next got=%0d@%0d exp=0@%0d", next_p, next_e - pe, L + 2);
        end
        checks++;
        if (dup != 0) begin
            failures++; $display("FAIL hold_dup got=%0d exp=0", dup);
        end
        // lone holder: no re-grant while its request lingers
        hold[1] = 1;
        issue(1, 2'b10, 8'h30, 16'h1234);
        n = 0;
        while (!wbDoneToCache[1] && n < 20) begin tick(); n++; end
        dup = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (debugBusy || wbDoneToCache != '0) dup++;
        end
        checks++;
        if (dup != 0) begin
            failures++; $display("FAIL hold_alone got=%0d exp=0", dup);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        do_reset();
        issue(1, 2'b10, 8'h10, 16'h0055);
        n = 0;
        while (!wbDoneToCache[1] && n < 20) begin tick(); n++; end
        tick(); tick(); tick();
        issue(1, 2'b10, 8'h10, 16'h00AA);
        tick();            // G
        tick();            // G+1
        reset = 1'b1;
        tick();            // G+2 with reset
        reset = 1'b0;
        rw[3:2] = 2'b00;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wbDoneToCache != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL rstmid_pulse got=%0d exp=0", bad);
        end
        issue(2, 2'b01, 8'h10, 16'h0);
        n = 0;
        while (!rdEnToCache[2] && n < 20) begin tick(); n++; end
        checks++;
        if (!rdEnToCache[2] || dataToCache !== 16'h0055) begin
            failures++; $display("FAIL rstmid_read got=%b/%h exp=1/0055", rdEnToCache[2], dataToCache);
        end
    endtask

    task automatic test_illegal();
        int bad;
        do_reset();
        rw[5:4] = 2'b11;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (debugBusy || rdEnToCache != '0 || wbDoneToCache != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL illegal got=%0d exp=0", bad);
        end
        rw[5:4] = 2'b00;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rw[2*i +: 2] == 2'b00 && !pend_drop[i] && $urandom_range(0, 2) == 0) begin
                    hold[i] = ($urandom_range(0, 3) == 0);
                    issue(i, 2'($urandom_range(1, 2)), AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
            tick();
        end
        for (int i = 0; i < 40; i++) tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_ports();
        test_last_writer();
        test_hold();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
